// File: rtl/cocofdc_spi_master.sv
// cocofdc_spi_master: SPI mode-0 master for SET_ADDR/WRITE/READ commands; clock_50_i/reset_i, cmd_* valid/ready command port, rsp_* read response, sclk_o/mosi_o/miso_i/ss_o SPI pins
module cocofdc_spi_master #(
  parameter int CLK_DIV = 6,
  parameter int GAP = 16
) (
  input  logic        clock_50_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [15:0] cmd_addr_i,
  input  logic [7:0]  cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_data_o,
  output logic        sclk_o,
  output logic        mosi_o,
  input  logic        miso_i,
  output logic        ss_o
);
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_GAP, S_LAST, S_RECOVER} state_e;
  localparam logic [1:0] OP_SET = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;
  localparam logic [7:0] DM1 = 8'(CLK_DIV - 1);
  localparam logic [7:0] GM1 = 8'(GAP - 1);
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic        sclk_q, sclk_d;
  logic        ss_q, ss_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        miso_meta_q, miso_sync_q;
  logic        accept, half_done, last_byte;
  assign cmd_ready_o = (state_q == S_IDLE) && !reset_i;
  assign accept = cmd_valid_i && cmd_ready_o;
  assign half_done = cnt_q == DM1;
  assign last_byte = byte_q == ((op_q == OP_SET) ? 2'd2 : 2'd1);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o = rsp_data_q;
  assign sclk_o = sclk_q;
  assign mosi_o = shift_q[7];
  assign ss_o = ss_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    byte_d = byte_q;
    op_d = op_q;
    data_d = data_q;
    shift_d = shift_q;
    rx_d = rx_q;
    sclk_d = sclk_q;
    ss_d = ss_q;
    rsp_valid_d = 1'b0;
    rsp_data_d = rsp_data_q;
    case (state_q)
      S_IDLE: if (accept) begin
        op_d = cmd_op_i;
        // byte 1 comes from data_q[15:8], byte 2 from data_q[7:0]; READ sends a zero dummy
        data_d = (cmd_op_i == OP_SET) ? cmd_addr_i : (cmd_op_i == OP_WRITE) ? {cmd_wdata_i, 8'h00} : 16'h0000;
        byte_d = 2'd0;
        bit_d = 3'd0;
        // a NOP just spends one cycle in RECOVER so ready drops for exactly one cycle
        cnt_d = (cmd_op_i == OP_NOP) ? DM1 : 8'd0;
        state_d = (cmd_op_i == OP_NOP) ? S_RECOVER : S_SHIFT;
        ss_d = cmd_op_i == OP_NOP;
        shift_d = (cmd_op_i == OP_NOP) ? 8'h00 : {6'd0, cmd_op_i} + 8'd1;
      end
      S_SHIFT: begin
        cnt_d = cnt_q + 8'd1;
        if (half_done) begin
          cnt_d = 8'd0;
          sclk_d = !sclk_q;
          if (!sclk_q) rx_d = {rx_q[6:0], miso_sync_q};
          else begin
            shift_d = {shift_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              byte_d = byte_q + 2'd1;
              state_d = last_byte ? S_LAST : S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == GM1) begin
          cnt_d = 8'd0;
          state_d = S_SHIFT;
          shift_d = (byte_q == 2'd1) ? data_q[15:8] : data_q[7:0];
        end
      end
      S_LAST: begin
        cnt_d = cnt_q + 8'd1;
        if (half_done) begin
          cnt_d = 8'd0;
          state_d = S_RECOVER;
          ss_d = 1'b1;
          rsp_valid_d = op_q == OP_READ;
          rsp_data_d = (op_q == OP_READ) ? rx_q : rsp_data_q;
        end
      end
      S_RECOVER: begin
        cnt_d = cnt_q + 8'd1;
        if (half_done) begin
          cnt_d = 8'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock_50_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q <= 8'd0;
      bit_q <= 3'd0;
      byte_q <= 2'd0;
      op_q <= OP_NOP;
      data_q <= 16'h0000;
      shift_q <= 8'h00;
      rx_q <= 8'h00;
      sclk_q <= 1'b0;
      ss_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= 8'h00;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      op_q <= op_d;
      data_q <= data_d;
      shift_q <= shift_d;
      rx_q <= rx_d;
      sclk_q <= sclk_d;
      ss_q <= ss_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      miso_meta_q <= miso_i;
      miso_sync_q <= miso_meta_q;
    end
  end
endmodule

// File: tb/tb_cocofdc_spi_master.sv
// tb_cocofdc_spi_master: directed bench with an SPI SRAM slave model for cocofdc_spi_master
module tb_cocofdc_spi_master;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b11;
  logic [15:0] cmd_addr = 16'h0000;
  logic [7:0]  cmd_wdata = 8'h00;
  logic        cmd_ready, rsp_valid, sclk, mosi, ss, miso;
  logic [7:0]  rsp_data;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  cocofdc_spi_master #(.CLK_DIV(6), .GAP(16)) dut (
    .clock_50_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .sclk_o(sclk), .mosi_o(mosi), .miso_i(miso), .ss_o(ss)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic       sclk_p = 1'b0, ss_p = 1'b1, mosi_p = 1'b0;
  int         rise_t[$], fall_t[$], ss_gaps[$];
  logic [7:0] bytes[$];
  int         ss_fall_t = 0, ss_rise_t = 0, rv_cnt = 0, rv_t = 0, toggles = 0, accepts = 0, acc_t = 0;
  logic [7:0] rv_data = 8'h00;
  bit [7:0]   mem [0:65535];
  logic [15:0] ptr = 16'h0000;
  logic [7:0] sh = 8'h00, cmd = 8'h00, outb = 8'h00;
  int         bitn = 0, bytn = 0;
  wire [7:0]  nb = {sh[6:0], mosi};
  always @(negedge clk) begin
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      accepts <= accepts + 1;
      acc_t <= cyc;
    end
    if (sclk !== sclk_p || ss !== ss_p || mosi !== mosi_p) toggles <= toggles + 1;
    sclk_p <= sclk;
    ss_p <= ss;
    mosi_p <= mosi;
    if (rsp_valid === 1'b1) begin
      rv_cnt <= rv_cnt + 1;
      rv_t <= cyc;
      rv_data <= rsp_data;
    end
    if (ss === 1'b0 && ss_p === 1'b1) begin
      ss_fall_t <= cyc;
      ss_gaps.push_back(cyc - ss_rise_t);
    end
    if (ss === 1'b1 && ss_p === 1'b0) ss_rise_t <= cyc;
    if (ss !== 1'b0) begin
      bitn <= 0;
      bytn <= 0;
      outb <= 8'h00;
      miso <= 1'b0;
    end else if (sclk === 1'b1 && sclk_p === 1'b0) begin
      rise_t.push_back(cyc);
      sh <= nb;
      bitn <= (bitn == 7) ? 0 : bitn + 1;
      if (bitn == 7) begin
        bytes.push_back(nb);
        bytn <= bytn + 1;
        if (bytn == 0) cmd <= nb;
        else if (cmd == 8'h01) begin
          if (bytn == 1) ptr[15:8] <= nb;
          else ptr[7:0] <= nb;
        end else if (cmd == 8'h02) begin
          mem[ptr] <= nb;
          ptr <= ptr + 16'd1;
        end
        if (bytn == 0 && nb == 8'h03) begin
          outb <= mem[ptr];
          ptr <= ptr + 16'd1;
        end
      end
    end else if (sclk === 1'b0 && sclk_p === 1'b1) begin
      fall_t.push_back(cyc);
      miso <= outb[7];
      outb <= {outb[6:0], 1'b0};
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(output int t);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    chk("ready_timeout", 32'(n < 2000), 32'd1);
    t = cyc;
  endtask
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [7:0] w, output int t);
    int r;
    wait_ready(r);
    cmd_op = op;
    cmd_addr = a;
    cmd_wdata = w;
    cmd_valid = 1'b1;
    t = cyc;
    step();
    cmd_valid = 1'b0;
  endtask
  task automatic run(input logic [1:0] op, input logic [15:0] a, input logic [7:0] w, output int t, output int rt);
    issue(op, a, w, t);
    wait_ready(rt);
  endtask
  initial begin
    int t, rt, b0, r0, f0, v0, g0, a0, tg0;
    repeat (3) step();
    chk("rst_ss", ss, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_ready", cmd_ready, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", cmd_ready, 1);
    b0 = bytes.size(); r0 = rise_t.size();
    run(2'b00, 16'h8123, 8'h00, t, rt);
    chk("sa_nbytes", bytes.size() - b0, 3);
    chk("sa_b0", bytes[b0], 8'h01);
    chk("sa_b1", bytes[b0+1], 8'h81);
    chk("sa_b2", bytes[b0+2], 8'h23);
    chk("sa_rises", rise_t.size() - r0, 24);
    chk("sa_first_rise", rise_t[r0] - t, 7);
    chk("sa_ss_fall", ss_fall_t - t, 1);
    chk("sa_ss_rise", ss_rise_t - t, 327);
    chk("sa_ready", rt - t, 333);
    b0 = bytes.size(); r0 = rise_t.size(); f0 = fall_t.size();
    run(2'b01, 16'h0000, 8'hA5, t, rt);
    chk("wr_nbytes", bytes.size() - b0, 2);
    chk("wr_b0", bytes[b0], 8'h02);
    chk("wr_b1", bytes[b0+1], 8'hA5);
    chk("wr_gap", rise_t[r0+8] - fall_t[f0+7], 22);
    chk("wr_ss_rise", ss_rise_t - t, 215);
    chk("wr_ready", rt - t, 221);
    run(2'b00, 16'h0040, 8'h00, t, rt);
    run(2'b01, 16'h0000, 8'h3C, t, rt);
    run(2'b00, 16'h0040, 8'h00, t, rt);
    b0 = bytes.size(); v0 = rv_cnt;
    run(2'b10, 16'h0000, 8'h00, t, rt);
    chk("rd_b0", bytes[b0], 8'h03);
    chk("rd_b1", bytes[b0+1], 8'h00);
    chk("rd_pulses", rv_cnt - v0, 1);
    chk("rd_rv_time", rv_t - t, 215);
    chk("rd_rv_data", rv_data, 8'h3C);
    chk("rd_hold", rsp_data, 8'h3C);
    run(2'b00, 16'h0010, 8'h00, t, rt);
    run(2'b01, 16'h0000, 8'h11, t, rt);
    run(2'b01, 16'h0000, 8'h22, t, rt);
    run(2'b00, 16'h0010, 8'h00, t, rt);
    run(2'b10, 16'h0000, 8'h00, t, rt);
    chk("lb_rd1", rsp_data, 8'h11);
    run(2'b10, 16'h0000, 8'h00, t, rt);
    chk("lb_rd2", rsp_data, 8'h22);
    v0 = rv_cnt;
    issue(2'b10, 16'h0000, 8'h00, t);
    while (cyc < t + 50) step();
    reset = 1'b1;
    step();
    chk("mr_ss", ss, 1);
    chk("mr_sclk", sclk, 0);
    chk("mr_mosi", mosi, 0);
    chk("mr_ready", cmd_ready, 0);
    chk("mr_rsp_data", rsp_data, 8'h00);
    step();
    reset = 1'b0;
    #1;
    chk("mr_ready_after", cmd_ready, 1);
    repeat (300) step();
    chk("mr_no_rsp", rv_cnt - v0, 0);
    run(2'b00, 16'h0010, 8'h00, t, rt);
    run(2'b10, 16'h0000, 8'h00, t, rt);
    chk("mr_rd_data", rsp_data, 8'h11);
    chk("mr_rd_time", rv_t - t, 215);
    tg0 = toggles; v0 = rv_cnt;
    chk("nop_ready_in", cmd_ready, 1);
    cmd_op = 2'b11;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("nop_ready_low", cmd_ready, 0);
    step();
    chk("nop_ready_high", cmd_ready, 1);
    repeat (10) step();
    chk("nop_toggles", toggles - tg0, 0);
    chk("nop_no_rsp", rv_cnt - v0, 0);
    a0 = accepts; v0 = rv_cnt; g0 = ss_gaps.size();
    cmd_op = 2'b10;
    cmd_valid = 1'b1;
    t = cyc;
    repeat (500) step();
    cmd_valid = 1'b0;
    wait_ready(rt);
    chk("hold_accepts", accepts - a0, 3);
    chk("hold_last_acc", acc_t - t, 442);
    chk("hold_rsps", rv_cnt - v0, 3);
    chk("hold_gap1", ss_gaps[g0+1], 7);
    chk("hold_gap2", ss_gaps[g0+2], 7);
    chk("hold_last_data", rv_data, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
